// File: rtl/prog_lut_decoder.sv
// prog_lut_decoder: run-time programmable truth-table lookup behind a 2-stage valid/ready pipeline
module prog_lut_decoder #(
  parameter int IN_W = 3,
  parameter int OUT_W = 3,
  parameter logic [OUT_W*(1<<IN_W)-1:0] INIT = 24'hC60C2B
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] data_out,
  input  logic             cfg_we,
  input  logic [IN_W-1:0]  cfg_addr,
  input  logic [OUT_W-1:0] cfg_data
);
  localparam int DEPTH = 1 << IN_W;
  logic [OUT_W-1:0] tbl [DEPTH];
  logic [IN_W-1:0] code;
  logic s1_v, s2_take, s1_adv;
  assign s2_take = !out_valid || out_ready;
  assign s1_adv = s1_v && s2_take;
  assign in_ready = !s1_v || s2_take;
  // Truth table: reloads INIT on reset; a write lands at the edge, so a same-edge lookup sees old contents
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) tbl[k] <= INIT[k*OUT_W +: OUT_W];
    end else if (cfg_we) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end
  // Stage 1: code is captured only on an accepted request, keeping data_out independent of idle data_in
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      code <= '0;
    end else if (in_valid && in_ready) begin
      s1_v <= 1'b1;
      code <= data_in;
    end else if (s1_adv) begin
      s1_v <= 1'b0;
    end
  end
  // Stage 2: table read into data_out; holds stable under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out <= '0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      data_out <= tbl[code];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_prog_lut_decoder.sv
// tb_prog_lut_decoder: directed vector bench for prog_lut_decoder (default and 4-in/2-out variants)
module tb_prog_lut_decoder;
  typedef struct packed {logic [2:0] code; logic [2:0] exp;} vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b1, cfg_we = 1'b0;
  logic in_ready, out_valid;
  logic [2:0] data_in = '0, cfg_addr = '0, cfg_data = '0;
  logic [2:0] data_out;
  logic b_in_valid = 1'b0, b_cfg_we = 1'b0;
  logic b_in_ready, b_out_valid;
  logic [3:0] b_data_in = '0, b_cfg_addr = '0;
  logic [1:0] b_cfg_data = '0;
  logic [1:0] b_data_out;
  int checks = 0;
  int failures = 0;
  vec_t std_v[8];
  vec_t inv_v[8];

  always #5 clk = ~clk;

  prog_lut_decoder u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
  );

  prog_lut_decoder #(.IN_W(4), .OUT_W(2), .INIT(32'h0)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .data_in(b_data_in),
    .out_valid(b_out_valid), .out_ready(1'b1), .data_out(b_data_out),
    .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr), .cfg_data(b_cfg_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic stream(input vec_t v[8], input string name);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 1) chk({name, " latency"}, 32'(out_valid), 32'd0);
      if (c >= 2) begin
        chk({name, " valid"}, 32'(out_valid), 32'd1);
        chk({name, " data"}, 32'(data_out), 32'(v[c-2].exp));
      end
      in_valid = c < 8;
      data_in = c < 8 ? v[c%8].code : 3'd0;
    end
    @(negedge clk);
    chk({name, " drained"}, 32'(out_valid), 32'd0);
  endtask

  task automatic lookup(input logic [2:0] code, input logic [2:0] exp, input string name);
    @(negedge clk);
    in_valid = 1'b1;
    data_in = code;
    @(negedge clk);
    in_valid = 1'b0;
    data_in = 3'd0;
    @(negedge clk);
    chk({name, " valid"}, 32'(out_valid), 32'd1);
    chk({name, " data"}, 32'(data_out), 32'(exp));
  endtask

  initial begin
    std_v = '{'{3'd0, 3'd3}, '{3'd1, 3'd5}, '{3'd2, 3'd0}, '{3'd3, 3'd6},
              '{3'd4, 3'd0}, '{3'd5, 3'd4}, '{3'd6, 3'd1}, '{3'd7, 3'd6}};
    inv_v = '{'{3'd0, 3'd7}, '{3'd1, 3'd6}, '{3'd2, 3'd5}, '{3'd3, 3'd4},
              '{3'd4, 3'd3}, '{3'd5, 3'd2}, '{3'd6, 3'd1}, '{3'd7, 3'd0}};
    repeat (2) @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst data_out", 32'(data_out), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst b out_valid", 32'(b_out_valid), 32'd0);
    rst = 1'b0;
    stream(std_v, "std");
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    data_in = 3'd1;
    @(negedge clk);
    chk("bp ready after 1", 32'(in_ready), 32'd1);
    data_in = 3'd3;
    @(negedge clk);
    data_in = 3'd7;
    #1;
    chk("bp ready full", 32'(in_ready), 32'd0);
    chk("bp valid", 32'(out_valid), 32'd1);
    chk("bp data", 32'(data_out), 32'd5);
    repeat (3) begin
      @(negedge clk);
      chk("bp hold valid", 32'(out_valid), 32'd1);
      chk("bp hold data", 32'(data_out), 32'd5);
      chk("bp hold ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp release ready", 32'(in_ready), 32'd1);
    chk("bp out0", 32'(data_out), 32'd5);
    @(negedge clk);
    chk("bp out1 valid", 32'(out_valid), 32'd1);
    chk("bp out1", 32'(data_out), 32'd6);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp out2 valid", 32'(out_valid), 32'd1);
    chk("bp out2", 32'(data_out), 32'd6);
    @(negedge clk);
    chk("bp drained", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    data_in = 3'd2;
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we = 1'b1;
    cfg_addr = 3'd2;
    cfg_data = 3'd7;
    @(negedge clk);
    cfg_we = 1'b0;
    chk("wr old valid", 32'(out_valid), 32'd1);
    chk("wr old data", 32'(data_out), 32'd0);
    lookup(3'd2, 3'd7, "wr new");
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      cfg_we = 1'b1;
      cfg_addr = 3'(k);
      cfg_data = ~3'(k);
    end
    @(negedge clk);
    cfg_we = 1'b0;
    stream(inv_v, "inv");
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    data_in = 3'd0;
    @(negedge clk);
    data_in = 3'd1;
    @(negedge clk);
    chk("pre-rst valid", 32'(out_valid), 32'd1);
    chk("pre-rst data", 32'(data_out), 32'd7);
    in_valid = 1'b0;
    rst = 1'b1;
    cfg_we = 1'b1;
    cfg_addr = 3'd3;
    cfg_data = 3'd1;
    @(negedge clk);
    rst = 1'b0;
    cfg_we = 1'b0;
    chk("mid-rst valid", 32'(out_valid), 32'd0);
    chk("mid-rst data", 32'(data_out), 32'd0);
    chk("mid-rst ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no stale", 32'(out_valid), 32'd0);
    end
    lookup(3'd3, 3'd6, "init 3");
    lookup(3'd2, 3'd0, "init 2");
    @(negedge clk);
    b_cfg_we = 1'b1;
    b_cfg_addr = 4'd15;
    b_cfg_data = 2'd2;
    @(negedge clk);
    b_cfg_we = 1'b0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        chk("b valid", 32'(b_out_valid), 32'd1);
        chk("b data", 32'(b_data_out), c == 17 ? 32'd2 : 32'd0);
      end
      b_in_valid = c < 16;
      b_data_in = 4'(c);
    end
    @(negedge clk);
    chk("b drained", 32'(b_out_valid), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
